// File: rtl/pipe_pkg.sv
// Shared types and payload widths for the pipeline-stage registers.
// Widths are the packed payload sizes of each inter-stage boundary.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    // IF/ID: pc + instruction
    localparam int IF_ID_W  = 32 + 32;
    // ID/EX: ctrl + pc + rs1 val + rs2 val + rs1/rs2/rd indices
    localparam int ID_EX_W  = 9 + 32 + 32 + 32 + 5 + 5 + 5;
    // EX/MEM: ctrl + alu result + store data + rd
    localparam int EX_MEM_W = 5 + 32 + 32 + 5;
    // MEM/WB: ctrl + alu result + load data + rd
    localparam int MEM_WB_W = 2 + 32 + 32 + 5;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: count_q advances by one on each cycle inc is high,
// sticks at all-ones, and clears only on asynchronous reset. No backpressure.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage, 1-cycle latency, flush kills held entries.
// SKID=1 adds a second entry so in_ready is a flop; SKID=0 is a single entry with combinational in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = MEM_WB_W,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    logic        in_fire;
    logic        out_fire;
    pipe_state_t state_q;
    pipe_state_t state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    generate
        if (SKID != 0) begin : g_skid
            logic [WIDTH-1:0] skid_q;
            logic [WIDTH-1:0] skid_d;
            logic             in_ready_q;
            logic             in_ready_d;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush) begin
                    // Killed stage must present reg_write=0 downstream.
                    state_d = EMPTY;
                    main_d  = '0;
                end else begin
                    case (state_q)
                        EMPTY: begin
                            if (in_fire) begin
                                state_d = ONE;
                                main_d  = in_data;
                            end
                        end
                        ONE: begin
                            if (in_fire && out_fire) begin
                                main_d = in_data;
                            end else if (in_fire) begin
                                state_d = TWO;
                                skid_d  = in_data;
                            end else if (out_fire) begin
                                state_d = EMPTY;
                            end
                        end
                        TWO: begin
                            if (out_fire) begin
                                state_d = ONE;
                                main_d  = skid_q;
                            end
                        end
                        default: state_d = EMPTY;
                    endcase
                end
                in_ready_d = (state_d != TWO);
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_q    <= EMPTY;
                    main_q     <= '0;
                    skid_q     <= '0;
                    in_ready_q <= 1'b1;
                end else begin
                    state_q    <= state_d;
                    main_q     <= main_d;
                    skid_q     <= skid_d;
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                if (flush) begin
                    state_d = EMPTY;
                    main_d  = '0;
                end else if (in_fire) begin
                    state_d = ONE;
                    main_d  = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_q <= EMPTY;
                    main_q  <= '0;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                end
            end

            assign in_ready = out_ready | ~out_valid;
        end
    endgenerate

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Three stage variants share one stimulus stream; each is checked every cycle against a FIFO-occupancy model.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int W = MEM_WB_W;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] in_data;

    logic [2:0]   ir;
    logic [2:0]   ov;
    logic [W-1:0] od [3];
    logic [15:0]  sc0;
    logic [15:0]  sc1;
    logic [3:0]   sc2;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: each instance is a bounded FIFO of capacity 2 (skid) or 1.
    logic [W-1:0] mbuf  [3][2];
    logic [W-1:0] mlast [3];
    int           mcnt  [3];
    int           mstall[3];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(16)) u_dut_skid (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .stall_cnt(sc0)
    );

    pipe_stage_reg #(.WIDTH(W), .SKID(0), .CNT_W(16)) u_dut_noskid (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .stall_cnt(sc1)
    );

    pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(4)) u_dut_sat (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
        .stall_cnt(sc2)
    );

    task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cap_of(input int i);
        return (i == 1) ? 1 : 2;
    endfunction

    function automatic int cmax_of(input int i);
        return (i == 2) ? 15 : 65535;
    endfunction

    function automatic logic [15:0] sc_of(input int i);
        if (i == 0) return sc0;
        if (i == 1) return sc1;
        return {12'd0, sc2};
    endfunction

    function automatic logic exp_ready(input int i);
        if (cap_of(i) == 2) return (mcnt[i] < 2);
        return out_ready || (mcnt[i] == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mcnt[i]    = 0;
            mstall[i]  = 0;
            mlast[i]   = '0;
            mbuf[i][0] = '0;
            mbuf[i][1] = '0;
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            logic ofire;
            logic ifire;
            ofire = (mcnt[i] > 0) && out_ready;
            ifire = in_valid && exp_ready(i);
            if ((mcnt[i] > 0) && !out_ready && (mstall[i] < cmax_of(i))) mstall[i]++;
            if (flush) begin
                mcnt[i]  = 0;
                mlast[i] = '0;
            end else begin
                if (ofire) begin
                    mlast[i]   = mbuf[i][0];
                    mbuf[i][0] = mbuf[i][1];
                    mcnt[i]--;
                end
                if (ifire) begin
                    mbuf[i][mcnt[i]] = in_data;
                    mcnt[i]++;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("out_valid%0d", i), 80'(ov[i]), 80'(mcnt[i] > 0));
            check_eq($sformatf("in_ready%0d", i), 80'(ir[i]), 80'(exp_ready(i)));
            check_eq($sformatf("out_data%0d", i), 80'(od[i]),
                     80'((mcnt[i] > 0) ? mbuf[i][0] : mlast[i]));
            check_eq($sformatf("stall_cnt%0d", i), 80'(sc_of(i)), 80'(mstall[i]));
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv,
                         input logic [W-1:0] d, input logic ordy);
        @(negedge clk);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        if (!rst) model_reset();
        #1;
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_update();
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        tick();
    endtask

    initial begin
        logic         was_rdy;
        logic [W-1:0] d;

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        model_reset();

        // Reset with traffic offered
        drive(1'b0, 1'b0, 1'b1, W'(8'h55), 1'b1);
        check_eq("rst_in_ready", 80'(ir[0]), 80'd1);
        check_eq("rst_out_data", 80'(od[0]), 80'd0);
        tick();

        // Streaming 1..8
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 1'b0, 1'b1, W'(k), 1'b1);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check_eq("stream_last", 80'(od[0]), 80'd8);
        check_eq("stream_stall", 80'(sc0), 80'd0);
        tick();

        // Back-pressure: A, B fill the skid stage, C is held
        do_reset();
        drive(1'b1, 1'b0, 1'b1, W'(8'hA), 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1, W'(8'hB), 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1, W'(8'hC), 1'b0);
        check_eq("bp_in_ready", 80'(ir[0]), 80'd0);
        check_eq("bp_head", 80'(od[0]), 80'hA);
        tick();
        drive(1'b1, 1'b0, 1'b1, W'(8'hC), 1'b0); tick();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b0, 1'b1, W'(8'hC), 1'b1);
            was_rdy = ir[0];
            tick();
            if (was_rdy) break;
            if (k == 9) check_eq("bp_c_accept_timeout", 80'(was_rdy), 80'd1);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
            tick();
        end
        check_eq("bp_stall_cnt", 80'(sc0), 80'd3);
        check_eq("bp_tail", 80'(od[0]), 80'hC);

        // Flush while holding two entries
        do_reset();
        drive(1'b1, 1'b0, 1'b1, W'(8'hA), 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1, W'(8'hB), 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        check_eq("flush_out_valid", 80'(ov[0]), 80'd0);
        check_eq("flush_out_data", 80'(od[0]), 80'd0);
        check_eq("flush_in_ready", 80'(ir[0]), 80'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
            tick();
        end

        // Saturation of the 4-bit counter
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b0, 1'b1, W'(1), 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
        check_eq("sat_cnt4", 80'(sc2), 80'd15);
        check_eq("sat_cnt16", 80'(sc0), 80'd19);
        tick();

        // Single-entry variant: combinational in_ready
        do_reset();
        drive(1'b1, 1'b0, 1'b1, W'(5), 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1, W'(6), 1'b0);
        check_eq("s0_ready_low", 80'(ir[1]), 80'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, W'(6), 1'b1);
        check_eq("s0_ready_high", 80'(ir[1]), 80'd1);
        check_eq("s0_head5", 80'(od[1]), 80'd5);
        tick();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check_eq("s0_data6", 80'(od[1]), 80'd6);
        tick();

        // Randomized traffic with occasional flush and async reset
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            logic rst;
            logic fl;
            logic iv;
            logic ordy;
            rst  = ($urandom_range(0, 99) != 0);
            fl   = ($urandom_range(0, 31) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ((k % 200) < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            d    = W'({$urandom(), $urandom(), $urandom()});
            drive(rst, fl, iv, d, ordy);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
